// File: rtl/lc3b_types.sv
// Shared LC-3b line/word types and the eviction write buffer FSM state encoding.
package lc3b_types;

    typedef logic [127:0] lc3b_block;
    typedef logic [15:0]  lc3b_word;
    typedef logic [11:0]  lc3b_tag;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_MEM = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } ewb_state_t;

endpackage

// File: rtl/ewb_entry_array.sv
// FIFO of dirty lines (tag/data/valid) with tag lookup and in-place data update.
// The lookup reports the newest valid entry whose tag matches.
module ewb_entry_array
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      update,
    input  logic      pop,
    input  lc3b_tag   wr_tag,
    input  lc3b_block wr_data,
    input  logic      sel_head,
    output logic      hit,
    output logic      full,
    output logic      empty,
    output lc3b_tag   head_tag,
    output lc3b_block entry_data
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    lc3b_tag            tag_q   [DEPTH];
    lc3b_block          data_q  [DEPTH];
    logic               valid_q [DEPTH];
    logic [IDX_W-1:0]   head_q, tail_q, hit_idx;
    logic [CNT_W-1:0]   count_q;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scan oldest to newest so the last match (newest) wins.
    always_comb begin
        int unsigned      k;
        logic [IDX_W-1:0] idx;
        k       = 0;
        idx     = '0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            k   = (int'(head_q) + i) % int'(DEPTH);
            idx = k[IDX_W-1:0];
            if (i < int'(count_q) && valid_q[idx] && tag_q[idx] == wr_tag) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign head_tag   = tag_q[head_q];
    assign entry_data = sel_head ? data_q[head_q] : data_q[hit_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
                valid_q[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                tag_q[tail_q]   <= wr_tag;
                data_q[tail_q]  <= wr_data;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= wrap_inc(tail_q);
            end
            if (update) begin
                data_q[hit_idx] <= wr_data;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= wrap_inc(head_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/eviction_write_buffer.sv
// Eviction write buffer: queues dirty lines from L1, drains them to pmem when idle.
// Define EWB_FORWARD_EN to return read hits from the buffer instead of draining first.
module eviction_write_buffer
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      up_read,
    input  logic      up_write,
    input  lc3b_word  up_address,
    input  lc3b_block up_wdata,
    output lc3b_block up_rdata,
    output logic      up_resp,
    output logic      pmem_read,
    output logic      pmem_write,
    output lc3b_word  pmem_address,
    output lc3b_block pmem_wdata,
    input  lc3b_block pmem_rdata,
    input  logic      pmem_resp
);
    ewb_state_t state_q, state_d;
    lc3b_block  rdata_q, rdata_d;
    logic       push, update, pop, hit, full, empty;
    lc3b_tag    head_tag;
    lc3b_block  entry_data;

    ewb_entry_array #(
        .DEPTH(DEPTH)
    ) u_entries (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .update     (update),
        .pop        (pop),
        .wr_tag     (up_address[15:4]),
        .wr_data    (up_wdata),
        .sel_head   (state_q == DRAIN),
        .hit        (hit),
        .full       (full),
        .empty      (empty),
        .head_tag   (head_tag),
        .entry_data (entry_data)
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        push    = 1'b0;
        update  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (up_read) begin
`ifdef EWB_FORWARD_EN
                    if (hit) begin
                        rdata_d = entry_data;
                        state_d = RESP;
                    end else begin
                        state_d = RD_MEM;
                    end
`else
                    // Flush older lines up to the hit so memory holds the latest copy.
                    state_d = hit ? DRAIN : RD_MEM;
`endif
                end else if (up_write) begin
                    if (hit) begin
                        update  = 1'b1;
                        state_d = RESP;
                    end else if (!full) begin
                        push    = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (!empty) begin
                    state_d = DRAIN;
                end
            end
            RD_MEM: begin
                if (pmem_resp) begin
                    rdata_d = pmem_rdata;
                    state_d = RESP;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        up_resp      = (state_q == RESP);
        up_rdata     = rdata_q;
        pmem_read    = (state_q == RD_MEM);
        pmem_write   = (state_q == DRAIN);
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state_q == RD_MEM) begin
            pmem_address = up_address;
        end else if (state_q == DRAIN) begin
            pmem_address = {head_tag, 4'b0000};
            pmem_wdata   = entry_data;
        end
    end

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Directed self-checking bench for eviction_write_buffer (DEPTH=2).
// Honours EWB_FORWARD_EN for the read-hit scenario.
module tb_eviction_write_buffer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         up_read = 1'b0;
    logic         up_write = 1'b0;
    logic [15:0]  up_address = '0;
    logic [127:0] up_wdata = '0;
    logic [127:0] up_rdata;
    logic         up_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] DATA_A = {4{32'hAAAA_0001}};
    localparam logic [127:0] DATA_B = {4{32'hBBBB_0002}};
    localparam logic [127:0] DATA_C = {4{32'hCCCC_0003}};
    localparam logic [127:0] DATA_D = {4{32'hDDDD_0004}};
    localparam logic [127:0] DATA_E = {4{32'hEEEE_0005}};
    localparam logic [127:0] DATA_F = {4{32'hF0F0_0006}};
    localparam logic [127:0] DATA_R = {4{32'h1234_5678}};
    localparam logic [127:0] DATA_X = {4{32'h5A5A_0007}};

    eviction_write_buffer #(
        .DEPTH(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_read      (up_read),
        .up_write     (up_write),
        .up_address   (up_address),
        .up_wdata     (up_wdata),
        .up_rdata     (up_rdata),
        .up_resp      (up_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    // Issue a write from an IDLE-bound negedge; returns up_resp seen one cycle later.
    task automatic write_req(input logic [15:0] a, input logic [127:0] d, output logic lat1);
        up_write   = 1'b1;
        up_address = a;
        up_wdata   = d;
        @(negedge clk);
        lat1     = up_resp;
        up_write = 1'b0;
        @(negedge clk);
    endtask

    // Wait (bounded) for a drain, record it, and acknowledge it with a one-cycle pmem_resp.
    task automatic drain_one(output logic [15:0] a, output logic [127:0] d, output logic seen);
        seen = 1'b0;
        a    = '0;
        d    = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pmem_write === 1'b1) begin
                seen = 1'b1;
                a    = pmem_address;
                d    = pmem_wdata;
            end
        end
        if (seen) begin
            pmem_resp = 1'b1;
            @(negedge clk);
            pmem_resp = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (up_resp !== 1'b0) begin
            errors++; $display("FAIL rst_up_resp: got %b expected 0", up_resp);
        end
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            errors++; $display("FAIL rst_pmem_rw: got %b%b expected 00", pmem_read, pmem_write);
        end
        checks++;
        if (pmem_address !== 16'h0) begin
            errors++; $display("FAIL rst_pmem_address: got %h expected 0000", pmem_address);
        end
        checks++;
        if (pmem_wdata !== 128'h0) begin
            errors++; $display("FAIL rst_pmem_wdata: got %h expected 0", pmem_wdata);
        end
        checks++;
        if (up_rdata !== 128'h0) begin
            errors++; $display("FAIL rst_up_rdata: got %h expected 0", up_rdata);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: rw=%b%b expected 00", pmem_read, pmem_write);
        end
    endtask

    task automatic test_write_drain();
        logic lat;
        write_req(16'h1230, DATA_A, lat);
        checks++;
        if (lat !== 1'b1) begin
            errors++; $display("FAIL wr_latency: up_resp=%b expected 1", lat);
        end
        checks++;
        if (up_resp !== 1'b0) begin
            errors++; $display("FAIL resp_pulse: up_resp=%b expected 0", up_resp);
        end
        @(negedge clk);
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin
            errors++; $display("FAIL drain_rw: rw=%b%b expected 01", pmem_read, pmem_write);
        end
        checks++;
        if (pmem_address !== 16'h1230) begin
            errors++; $display("FAIL drain_addr: got %h expected 1230", pmem_address);
        end
        checks++;
        if (pmem_wdata !== DATA_A) begin
            errors++; $display("FAIL drain_data: got %h expected %h", pmem_wdata, DATA_A);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pmem_write !== 1'b0) begin
            errors++; $display("FAIL drain_once: pmem_write=%b expected 0", pmem_write);
        end
    endtask

    task automatic test_full_stall();
        logic lat1, lat2, seen, resp_seen;
        logic [15:0]  a;
        logic [127:0] d;
        write_req(16'h1000, DATA_A, lat1);
        write_req(16'h2000, DATA_B, lat2);
        checks++;
        if (lat1 !== 1'b1 || lat2 !== 1'b1) begin
            errors++; $display("FAIL fill_latency: got %b%b expected 11", lat1, lat2);
        end
        up_write   = 1'b1;
        up_address = 16'h3000;
        up_wdata   = DATA_C;
        @(negedge clk);
        checks++;
        if (pmem_write !== 1'b1 || pmem_address !== 16'h1000) begin
            errors++; $display("FAIL stall_drain: wr=%b addr=%h expected 1/1000",
                               pmem_write, pmem_address);
        end
        resp_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (up_resp !== 1'b0) resp_seen = 1'b1;
        end
        checks++;
        if (resp_seen !== 1'b0) begin
            errors++; $display("FAIL full_stall: up_resp seen=%b expected 0", resp_seen);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (up_resp !== 1'b1) begin
            errors++; $display("FAIL accept_after_pop: up_resp=%b expected 1", up_resp);
        end
        up_write = 1'b0;
        drain_one(a, d, seen);
        checks++;
        if (seen !== 1'b1 || a !== 16'h2000 || d !== DATA_B) begin
            errors++; $display("FAIL fifo_second: seen=%b addr=%h expected 2000", seen, a);
        end
        drain_one(a, d, seen);
        checks++;
        if (seen !== 1'b1 || a !== 16'h3000 || d !== DATA_C) begin
            errors++; $display("FAIL fifo_third: seen=%b addr=%h expected 3000", seen, a);
        end
    endtask

    task automatic test_coalesce();
        logic lat, seen, extra;
        logic [15:0]  a;
        logic [127:0] d;
        write_req(16'h1000, DATA_A, lat);
        write_req(16'h2000, DATA_X, lat);
        write_req(16'h1008, DATA_B, lat);
        checks++;
        if (lat !== 1'b1) begin
            errors++; $display("FAIL coalesce_latency: up_resp=%b expected 1", lat);
        end
        drain_one(a, d, seen);
        checks++;
        if (seen !== 1'b1 || a !== 16'h1000 || d !== DATA_B) begin
            errors++; $display("FAIL coalesce_data: addr=%h data=%h expected 1000/%h",
                               a, d, DATA_B);
        end
        drain_one(a, d, seen);
        checks++;
        if (seen !== 1'b1 || a !== 16'h2000 || d !== DATA_X) begin
            errors++; $display("FAIL coalesce_second: seen=%b addr=%h expected 2000", seen, a);
        end
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (pmem_write !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0) begin
            errors++; $display("FAIL coalesce_occupancy: extra drain=%b expected 0", extra);
        end
    endtask

    task automatic test_read_hit();
        logic lat;
        write_req(16'h4000, DATA_C, lat);
        up_read    = 1'b1;
        up_address = 16'h4004;
        @(negedge clk);
`ifdef EWB_FORWARD_EN
        begin
            logic seen;
            logic [15:0]  a;
            logic [127:0] d;
            checks++;
            if (up_resp !== 1'b1 || up_rdata !== DATA_C) begin
                errors++; $display("FAIL fwd_hit: resp=%b data=%h expected 1/%h",
                                   up_resp, up_rdata, DATA_C);
            end
            checks++;
            if (pmem_read !== 1'b0) begin
                errors++; $display("FAIL fwd_no_pmem: pmem_read=%b expected 0", pmem_read);
            end
            up_read = 1'b0;
            drain_one(a, d, seen);
            checks++;
            if (seen !== 1'b1 || a !== 16'h4000) begin
                errors++; $display("FAIL fwd_drain: seen=%b addr=%h expected 4000", seen, a);
            end
        end
`else
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h4000) begin
            errors++; $display("FAIL hit_drain_first: rw=%b%b addr=%h expected 01/4000",
                               pmem_read, pmem_write, pmem_address);
        end
        checks++;
        if (pmem_wdata !== DATA_C) begin
            errors++; $display("FAIL hit_drain_data: got %h expected %h", pmem_wdata, DATA_C);
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address[15:4] !== 12'h400) begin
            errors++; $display("FAIL hit_then_read: rw=%b%b addr=%h expected 10/400x",
                               pmem_read, pmem_write, pmem_address);
        end
        pmem_rdata = DATA_R;
        pmem_resp  = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        checks++;
        if (up_resp !== 1'b1 || up_rdata !== DATA_R) begin
            errors++; $display("FAIL hit_read_data: resp=%b data=%h expected 1/%h",
                               up_resp, up_rdata, DATA_R);
        end
        up_read = 1'b0;
        @(negedge clk);
`endif
    endtask

    task automatic test_read_miss();
        logic early;
        up_read    = 1'b1;
        up_address = 16'h5000;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h5000) begin
            errors++; $display("FAIL miss_rdmem: rw=%b%b addr=%h expected 10/5000",
                               pmem_read, pmem_write, pmem_address);
        end
        early = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (up_resp !== 1'b0 || pmem_read !== 1'b1) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++; $display("FAIL miss_hold: early resp or dropped read=%b expected 0", early);
        end
        pmem_rdata = DATA_D;
        pmem_resp  = 1'b1;
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        checks++;
        if (up_resp !== 1'b1 || up_rdata !== DATA_D) begin
            errors++; $display("FAIL miss_data: resp=%b data=%h expected 1/%h",
                               up_resp, up_rdata, DATA_D);
        end
        up_read = 1'b0;
        @(negedge clk);
        checks++;
        if (up_resp !== 1'b0 || pmem_read !== 1'b0) begin
            errors++; $display("FAIL miss_done: resp=%b rd=%b expected 0/0", up_resp, pmem_read);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic lat, seen, extra;
        logic [15:0]  a;
        logic [127:0] d;
        write_req(16'h6000, DATA_E, lat);
        @(negedge clk);
        checks++;
        if (pmem_write !== 1'b1) begin
            errors++; $display("FAIL pre_reset_drain: pmem_write=%b expected 1", pmem_write);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pmem_write !== 1'b0 || pmem_address !== 16'h0 || pmem_wdata !== 128'h0) begin
            errors++; $display("FAIL async_reset: wr=%b addr=%h expected 0/0000",
                               pmem_write, pmem_address);
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (pmem_write !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0) begin
            errors++; $display("FAIL reset_discard: drain after reset=%b expected 0", extra);
        end
        write_req(16'h7000, DATA_F, lat);
        drain_one(a, d, seen);
        checks++;
        if (seen !== 1'b1 || a !== 16'h7000 || d !== DATA_F) begin
            errors++; $display("FAIL post_reset_fifo: seen=%b addr=%h expected 7000", seen, a);
        end
    endtask

    initial begin
        test_reset();
        test_write_drain();
        test_full_stall();
        test_coalesce();
        test_read_hit();
        test_read_miss();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eviction_write_buffer.md
EVICTION_WRITE_BUFFER -- requirements
Module: eviction_write_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 2, number of buffered dirty lines (legal 1..4).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: up_read  in  1  line read request from arbitrated L1 side; held until up_resp.
REQ-005 SHALL have port: up_write  in  1  line write (eviction) request; held until up_resp.
REQ-006 SHALL have port: up_address  in  16  byte address; bits [15:4] form the line tag.
REQ-007 SHALL have port: up_wdata  in  128  eviction line data.
REQ-008 SHALL have port: up_rdata  out  128  read line data, valid while up_resp=1.
REQ-009 SHALL have port: up_resp  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports: pmem_read out 1; pmem_write out 1; pmem_address out 16; pmem_wdata out 128; pmem_rdata in 128; pmem_resp in 1 (physical memory, request held until pmem_resp).

Function
REQ-011 SHALL implement FSM states IDLE, RD_MEM, DRAIN, RESP.
REQ-012 SHALL, in IDLE with up_write and a non-full buffer, or with a tag matching a valid entry, capture the line and go to RESP; up_resp is asserted the following cycle (latency 1).
REQ-013 SHALL coalesce: a write whose tag matches a valid entry overwrites that entry's data in place, allocates nothing, and is accepted even when full.
REQ-014 SHALL stall up_write with no tag match while full (no up_resp) until a drain pops an entry.
REQ-015 SHALL, in IDLE with up_read and a tag hit, return the matching entry data via RESP (latency 1, no pmem access).
REQ-016 SHALL, in IDLE with up_read and a miss, enter RD_MEM: drive pmem_read=1 and pmem_address=up_address until pmem_resp, register pmem_rdata, then RESP.
REQ-017 SHALL, in IDLE with no upstream request and a non-empty buffer, enter DRAIN: write the oldest entry (FIFO order) with pmem_write=1 until pmem_resp, then pop it and return to IDLE.
REQ-018 SHALL never abort a DRAIN; an upstream request arriving during DRAIN waits until it completes.
REQ-019 SHALL give up_read priority over drain in IDLE; simultaneous up_read and up_write is illegal, and up_read wins.
REQ-020 SHALL return from RESP to IDLE unconditionally; a request present in the cycle after up_resp is treated as new.
REQ-021 SHALL wrap head/tail pointers modulo DEPTH and track occupancy 0..DEPTH; full and empty are exact.
REQ-022 SHALL keep pmem_read and pmem_write mutually exclusive and never assert either outside RD_MEM/DRAIN.

Reset
REQ-023 SHALL on rst_n=0 immediately go to IDLE, invalidate all entries, zero pointers and occupancy, and drive up_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, and up_rdata=0.
REQ-024 SHALL discard buffered lines on reset mid-operation, including a DRAIN in flight.

Configuration
REQ-025 SHALL honour macro EWB_FORWARD_EN: when defined, REQ-015 read-hit forwarding applies. When undefined, a read hit instead drains entries from oldest until the matching entry is written, then performs RD_MEM.

Structure
REQ-026 SHALL place lc3b_block (128-bit line) and lc3b_word in package lc3b_types, and the FSM state enum in the same package.
REQ-027 SHALL use one sub-module, ewb_entry_array: DEPTH tag/data/valid registers, FIFO pointers, and a tag-match vector returning the newest matching index.

Verification
REQ-028 SHALL cover: write 0x1230 data A while empty -> up_resp at cycle+1, then DRAIN with pmem_address=0x1230, pmem_wdata=A.
REQ-029 SHALL cover: writes 0x1000 and 0x2000 (DEPTH=2, pmem_resp held 0), then write 0x3000 -> no up_resp until the 0x1000 drain pmem_resp; then accept.
REQ-030 SHALL cover: write 0x1000 data A, then write 0x1008 data B while full -> coalesced, occupancy unchanged, and the later drain writes B.
REQ-031 SHALL cover: buffered 0x4000 data C, read 0x4004 -> with EWB_FORWARD_EN, up_rdata=C at cycle+1 and no pmem_read; without it, pmem_write 0x4000 precedes pmem_read 0x4000.
REQ-032 SHALL cover: read miss 0x5000, with pmem_resp after 5 cycles and pmem_rdata=D -> up_rdata=D and up_resp one cycle after pmem_resp.
REQ-033 SHALL cover: rst_n low during DRAIN -> pmem_write=0 immediately, and after release the buffer is empty with no drain.
